// File: rtl/rv_pkg.sv
// Shared RV32I decode definitions: opcodes, the id_ex control bundle and its bubble value.
package rv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    // Field order matches the id_ex control input ports.
    typedef struct packed {
        logic pcsrc;
        logic alusrc;
        logic memtoreg;
        logic we;
        logic reg_en;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: IF/ID instruction, EX hazard info, writeback port and the id_ex bundle.
interface decode_stage_if;
    import rv_pkg::*;

    logic [31:0]     instr;
    logic            instr_valid;
    logic            flush;
    logic [4:0]      ex_rd;
    logic            ex_memtoreg;
    logic            ex_reg_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            wb_en;

    logic [XLEN-1:0] data_out_1;
    logic [XLEN-1:0] data_out_2;
    logic [4:0]      rd_out;
    logic [XLEN-1:0] imm_out;
    logic            pcsrc_out;
    logic            alusrc_out;
    logic            memtoreg_out;
    logic            we_out;
    logic            reg_en_out;
    logic            stall;
    logic            illegal;

    modport master (
        output instr, instr_valid, flush, ex_rd, ex_memtoreg, ex_reg_en, wb_rd, wb_data, wb_en,
        input  data_out_1, data_out_2, rd_out, imm_out, pcsrc_out, alusrc_out,
               memtoreg_out, we_out, reg_en_out, stall, illegal
    );

    modport slave (
        input  instr, instr_valid, flush, ex_rd, ex_memtoreg, ex_reg_en, wb_rd, wb_data, wb_en,
        output data_out_1, data_out_2, rd_out, imm_out, pcsrc_out, alusrc_out,
               memtoreg_out, we_out, reg_en_out, stall, illegal
    );

endinterface

// File: rtl/decode_stage_regfile.sv
// Integer register file: 2 combinational read ports with write-through bypass, 1 write port.
module regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    input  logic [4:0]      wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            wr_en,
    output logic [XLEN-1:0] rd_data_1,
    output logic [XLEN-1:0] rd_data_2
);

    logic [XLEN-1:0] regs [NREG];
    logic            wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_1 = regs[rs1];
        if (rs1 == '0)
            rd_data_1 = '0;
        else if (wr_live && wr_addr == rs1)
            rd_data_1 = wr_data;
    end

    always_comb begin
        rd_data_2 = regs[rs2];
        if (rs2 == '0)
            rd_data_2 = '0;
        else if (wr_live && wr_addr == rs2)
            rd_data_2 = wr_data;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I-subset decode stage: operand read, immediate/control generation, load-use stall.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input logic           clock,
    input logic           reset_n,
    decode_stage_if.slave bus
);

    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] rdata_1;
    logic [XLEN-1:0] rdata_2;
    ctrl_t           ctrl;
    ctrl_t           ctrl_q;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            legal;
    logic            uses_rs2;
    logic            rs_match;
    logic            stall;
    logic            bubble;
    logic            unused_funct3;

    assign opcode        = bus.instr[6:0];
    assign rs1           = bus.instr[19:15];
    assign rs2           = bus.instr[24:20];
    assign unused_funct3 = ^bus.instr[14:12];

    regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .rs1       (rs1),
        .rs2       (rs2),
        .wr_addr   (bus.wb_rd),
        .wr_data   (bus.wb_data),
        .wr_en     (bus.wb_en),
        .rd_data_1 (rdata_1),
        .rd_data_2 (rdata_2)
    );

    always_comb begin
        ctrl     = BUBBLE;
        imm      = '0;
        rd       = '0;
        legal    = 1'b1;
        uses_rs2 = 1'b0;
        case (opcode)
            OP_R: begin
                ctrl.reg_en = 1'b1;
                rd          = bus.instr[11:7];
                uses_rs2    = 1'b1;
            end
            OP_IMM, OP_LOAD: begin
                ctrl.alusrc   = 1'b1;
                ctrl.reg_en   = 1'b1;
                ctrl.memtoreg = (opcode == OP_LOAD);
                rd            = bus.instr[11:7];
                imm           = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};
            end
            OP_STORE: begin
                ctrl.alusrc = 1'b1;
                ctrl.we     = 1'b1;
                uses_rs2    = 1'b1;
                imm         = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            end
            OP_BRANCH: begin
                ctrl.pcsrc = 1'b1;
                uses_rs2   = 1'b1;
                imm        = {{(XLEN-13){bus.instr[31]}}, bus.instr[31], bus.instr[7],
                              bus.instr[30:25], bus.instr[11:8], 1'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal opcodes read no registers, so they never trigger a load-use stall.
    assign rs_match = legal && ((bus.ex_rd == rs1) || (uses_rs2 && bus.ex_rd == rs2));
    assign stall    = reset_n && bus.instr_valid && !bus.flush && bus.ex_memtoreg &&
                      bus.ex_reg_en && (bus.ex_rd != '0) && rs_match;
    assign bubble   = !reset_n || stall || bus.flush || !bus.instr_valid || !legal;
    assign ctrl_q   = bubble ? BUBBLE : ctrl;

    assign bus.stall        = stall;
    assign bus.illegal      = reset_n && bus.instr_valid && !bus.flush && !legal;
    assign bus.pcsrc_out    = ctrl_q.pcsrc;
    assign bus.alusrc_out   = ctrl_q.alusrc;
    assign bus.memtoreg_out = ctrl_q.memtoreg;
    assign bus.we_out       = ctrl_q.we;
    assign bus.reg_en_out   = ctrl_q.reg_en;
    assign bus.rd_out       = bubble ? '0 : rd;
    assign bus.imm_out      = bubble ? '0 : imm;
    // Bypass could otherwise leak wb_data onto the operands while in reset.
    assign bus.data_out_1   = reset_n ? rdata_1 : '0;
    assign bus.data_out_2   = reset_n ? rdata_2 : '0;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed vectors push expectations, a negedge monitor compares.
module tb_decode_stage;
    import rv_pkg::*;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    decode_stage_if bus ();

    decode_stage #(.XLEN(32), .NREG(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  ctrl;
        logic        stall;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    task automatic expect_out(input string name, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [4:0] rd, input logic [31:0] imm, input logic [4:0] ctrl,
                              input logic stall, input logic ill);
        exp_t e;
        e.name = name; e.d1 = d1; e.d2 = d2; e.rd = rd; e.imm = imm;
        e.ctrl = ctrl; e.stall = stall; e.ill = ill;
        q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] instr, input logic valid, input logic flush,
                         input logic [4:0] ex_rd, input logic ex_mem, input logic ex_ren,
                         input logic [4:0] wb_rd, input logic [31:0] wb_data, input logic wb_en);
        bus.instr = instr; bus.instr_valid = valid; bus.flush = flush;
        bus.ex_rd = ex_rd; bus.ex_memtoreg = ex_mem; bus.ex_reg_en = ex_ren;
        bus.wb_rd = wb_rd; bus.wb_data = wb_data; bus.wb_en = wb_en;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    // Monitor: the DUT is combinational, so every negedge presents a result for the pending vector.
    exp_t         m_e;
    logic [107:0] m_act;
    logic [107:0] m_req;
    always @(negedge clock) begin
        while (q.size() > 0) begin
            m_e   = q.pop_front();
            m_act = {bus.data_out_1, bus.data_out_2, bus.rd_out, bus.imm_out,
                     bus.pcsrc_out, bus.alusrc_out, bus.memtoreg_out, bus.we_out, bus.reg_en_out,
                     bus.stall, bus.illegal};
            m_req = {m_e.d1, m_e.d2, m_e.rd, m_e.imm, m_e.ctrl, m_e.stall, m_e.ill};
            n_checks++;
            if (m_act !== m_req) begin
                n_fails++;
                $display("FAIL %s: got d1=%h d2=%h rd=%0d imm=%h ctrl=%b stall=%b ill=%b; expected d1=%h d2=%h rd=%0d imm=%h ctrl=%b stall=%b ill=%b",
                         m_e.name, bus.data_out_1, bus.data_out_2, bus.rd_out, bus.imm_out,
                         {bus.pcsrc_out, bus.alusrc_out, bus.memtoreg_out, bus.we_out, bus.reg_en_out},
                         bus.stall, bus.illegal,
                         m_e.d1, m_e.d2, m_e.rd, m_e.imm, m_e.ctrl, m_e.stall, m_e.ill);
            end
        end
    end

    // ctrl field order: {pcsrc, alusrc, memtoreg, we, reg_en}
    initial begin
        reset_n = 1'b0;
        drive(32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        expect_out("reset", 32'h0, 32'h0, 5'd0, 32'h0, 5'b00000, 1'b0, 1'b0);

        next_cycle();
        reset_n = 1'b1;
        drive(32'h0000_0000, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b1);
        expect_out("idle_wb_x5", 32'h0, 32'h0, 5'd0, 32'h0, 5'b00000, 1'b0, 1'b0);

        next_cycle();
        drive(32'h0002_80B3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        expect_out("add_x1_x5_x0", 32'hDEAD_BEEF, 32'h0, 5'd1, 32'h0, 5'b00001, 1'b0, 1'b0);

        next_cycle();
        drive(32'hFFF3_8113, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 32'h0000_1234, 1'b1);
        expect_out("addi_bypass", 32'h0000_1234, 32'h0, 5'd2, 32'hFFFF_FFFF, 5'b01001, 1'b0, 1'b0);

        next_cycle();
        drive(32'h0032_2423, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 32'h0, 1'b0);
        expect_out("sw_load_use_stall", 32'h0, 32'h0, 5'd0, 32'h0, 5'b00000, 1'b1, 1'b0);

        next_cycle();
        drive(32'h0032_2423, 1'b1, 1'b0, 5'd3, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0);
        expect_out("sw_after_stall", 32'h0, 32'h0, 5'd0, 32'h0000_0008, 5'b01010, 1'b0, 1'b0);

        next_cycle();
        drive(32'h0032_2423, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 32'h0, 1'b0);
        expect_out("flush_over_stall", 32'h0, 32'h0, 5'd0, 32'h0, 5'b00000, 1'b0, 1'b0);

        next_cycle();
        drive(32'h0000_00B3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 1'b1);
        expect_out("x0_write_bypass", 32'h0, 32'h0, 5'd1, 32'h0, 5'b00001, 1'b0, 1'b0);

        next_cycle();
        drive(32'h0000_00B3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        expect_out("x0_read_after", 32'h0, 32'h0, 5'd1, 32'h0, 5'b00001, 1'b0, 1'b0);

        next_cycle();
        drive(32'h0072_80B3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        expect_out("add_x5_x7", 32'hDEAD_BEEF, 32'h0000_1234, 5'd1, 32'h0, 5'b00001, 1'b0, 1'b0);

        next_cycle();
        drive(32'h0000_007F, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        expect_out("illegal_op", 32'h0, 32'h0, 5'd0, 32'h0, 5'b00000, 1'b0, 1'b1);

        next_cycle();
        drive(32'hFE72_8EE3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        expect_out("beq_neg4", 32'hDEAD_BEEF, 32'h0000_1234, 5'd0, 32'hFFFF_FFFC, 5'b10000, 1'b0, 1'b0);

        next_cycle();
        drive(32'h0042_A303, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd5, 32'hCAFE_F00D, 1'b1);
        expect_out("stall_with_bypass", 32'hCAFE_F00D, 32'h0, 5'd0, 32'h0, 5'b00000, 1'b1, 1'b0);

        next_cycle();
        drive(32'h0042_A303, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 32'h0, 1'b0);
        expect_out("lw_ex_rd_x0", 32'hCAFE_F00D, 32'h0, 5'd6, 32'h0000_0004, 5'b01101, 1'b0, 1'b0);

        next_cycle();
        drive(32'h0042_A303, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 32'h0, 1'b0);
        expect_out("lw_stall_rs1", 32'hCAFE_F00D, 32'h0, 5'd0, 32'h0, 5'b00000, 1'b1, 1'b0);

        next_cycle();
        reset_n = 1'b0;
        expect_out("reset_mid_stall", 32'h0, 32'h0, 5'd0, 32'h0, 5'b00000, 1'b0, 1'b0);

        next_cycle();
        reset_n = 1'b1;
        drive(32'h0072_80B3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        expect_out("regs_clear_after_reset", 32'h0, 32'h0, 5'd1, 32'h0, 5'b00001, 1'b0, 1'b0);

        next_cycle();
        next_cycle();
        n_checks++;
        if (q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d expectations unchecked, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the five-stage RISC-V pipeline, placed between the IF/ID register and the `id_ex` pipeline register. It holds the 32×32 integer register file, decodes the RV32I subset, and generates sign-extended immediates and the control bundle that `id_ex` latches. It also detects load-use hazards, stalling fetch and injecting a bubble.

## Interface
- `XLEN`, 32: datapath width.
- `NREG`, 32: architectural register count; x0 is hardwired to zero.

- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `instr`  in  32  instruction from IF/ID.
- `instr_valid`  in  1  IF/ID holds a real instruction (0 = bubble).
- `flush`  in  1  taken branch resolved in EX; current ID instruction is squashed.
- `ex_rd`  in  5  destination register of the instruction in EX (`id_ex` rd output).
- `ex_memtoreg`  in  1  instruction in EX is a load.
- `ex_reg_en`  in  1  instruction in EX writes the register file.
- `wb_rd`  in  5  writeback destination.
- `wb_data`  in  32  writeback data.
- `wb_en`  in  1  writeback enable.
- `data_out_1`, `data_out_2`  out  32  rs1/rs2 operand values.
- `rd_out`  out  5  destination index.
- `imm_out`  out  32  sign-extended immediate.
- `pcsrc_out`, `alusrc_out`, `memtoreg_out`, `we_out`, `reg_en_out`  out  1  control bundle: branch, ALU uses immediate, load, memory write, register write.
- `stall`  out  1  hold PC and IF/ID this cycle.
- `illegal`  out  1  unsupported opcode on a valid instruction.

## Operation
- Supported opcodes:
  - R-type 0110011: reg_en.
  - I-ALU 0010011: alusrc, reg_en.
  - LW 0000011: alusrc, memtoreg, reg_en.
  - SW 0100011: alusrc, we.
  - BEQ 1100011: pcsrc.
- Immediates:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - R: 0.
- rd_out: instr[11:7] for R, I-ALU and LW; 0 for SW and BEQ.
- Register file:
  - Write at posedge when wb_en=1 and wb_rd≠0.
  - Writes to x0 are ignored; reads of x0 return 0.
- Reads are combinational. Write-through bypass: if wb_en=1, wb_rd≠0 and wb_rd equals the read index, the output is wb_data in the same cycle.
- rs1 is used by every supported opcode. rs2 is used by R, SW and BEQ only.
- Load-use hazard: `stall` = instr_valid & ex_memtoreg & ex_reg_en & (ex_rd≠0) & (ex_rd matches a used rs).
- Bubble: all five control outputs forced to 0, rd_out=0 and imm_out=0. Data outputs keep their read values. A bubble is emitted when any of these hold:
  - stall=1
  - flush=1
  - instr_valid=0
  - illegal opcode
- flush has priority over stall: when flush=1, stall=0.
- `illegal` = instr_valid & ~flush & (opcode not in the supported set).

## Timing
- Decode, hazard detection and operand read are fully combinational from the inputs and the register array; zero-cycle latency into `id_ex`.
- Register write takes effect at the posedge. The bypass covers a same-cycle read.
- Stall lasts exactly one cycle per load-use pair: the next cycle, the EX slot holds the bubble, so ex_memtoreg=0.
- Reset (reset_n=0, asynchronous):
  - All 32 registers clear to 0 immediately.
  - While reset_n=0: controls, rd_out, imm_out, stall and illegal are 0; data outputs are 0.
- Reset asserted mid-stall: stall drops at once. After release, decode resumes on the first valid instruction.
- Simultaneous writeback and hazard are independent: bypass still applies to the read data while stall is asserted.

## Structure
- Shared package `rv_pkg`: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH), a control-bundle struct in `id_ex` port order, and a BUBBLE constant.
- One sub-module: `regfile` (2 read ports, 1 write port, async reset, internal bypass).
- Decode and hazard logic live in `decode_stage`.

## Test plan
- Reset, then write x5=0xDEADBEEF via wb. Decode `add x1,x5,x0` (0x000280B3) → data_out_1=0xDEADBEEF, reg_en_out=1, alusrc_out=0, rd_out=1.
- Same cycle: wb_en=1, wb_rd=7, wb_data=0x1234. Decode `addi x2,x7,-1` (0xFFF38113) → data_out_1=0x1234, imm_out=0xFFFFFFFF, alusrc_out=1.
- ex_memtoreg=1, ex_reg_en=1, ex_rd=3. Decode `sw x3,8(x4)` (0x00322423) → stall=1 and all controls 0. Then ex_memtoreg=0 → stall=0, we_out=1, imm_out=8, rd_out=0.
- Same load-use setup plus flush=1 → stall=0 and a bubble is emitted.
- wb write to x0 with 0xFFFFFFFF, then read x0 → data_out=0. Opcode 0x7F with instr_valid=1 → illegal=1 and a bubble.
- Assert reset_n=0 mid-stall → stall=0 immediately. All registers read 0 after release.
